// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO with wrap-bit pointers, registered read data,
// and full/empty flags decoded from the pointer registers alone.
module modport_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_op,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wptr, r_rptr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  w_wr, w_rd;
   // flags look only at registered pointers, so strobes never reach them combinationally
   assign empty   = r_wptr == r_rptr;
   assign full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_wr    = wr_en && !full;
   assign w_rd    = rd_en && !empty;
   assign data_op = r_data;
   always_ff @(posedge clk)
      if (w_wr && !rst) r_mem[r_wptr[AW-1:0]] <= data_in;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_data <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) begin
            r_data <= r_mem[r_rptr[AW-1:0]];
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: directed vector table plus hand sequences for wrap and mid-run reset.
module tb_modport_fifo;
   logic       clk = 1'b0;
   logic       rst, wr_en, rd_en;
   logic [7:0] data_in, data_op;
   logic       full, empty;
   int         checks = 0, errors = 0;

   typedef struct {
      logic       rst, wr, rd;
      logic [7:0] din;
      logic       e, f;
      logic [7:0] d;
   } vec_t;
   vec_t vq[$];

   modport_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_op(data_op), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] din,
                      input logic e, input logic f, input logic [7:0] d);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.e = e; v.f = f; v.d = d;
      vq.push_back(v);
   endtask

   task automatic step(input string nm, input logic r, input logic w, input logic rd,
                       input logic [7:0] din, input logic e, input logic f, input logic [7:0] d);
      rst = r; wr_en = w; rd_en = rd; data_in = din;
      @(posedge clk);
      #1;
      checks++;
      if ({empty, full, data_op} !== {e, f, d}) begin
         errors++;
         $display("FAIL %s got e=%b f=%b d=%h exp e=%b f=%b d=%h", nm, empty, full, data_op, e, f, d);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      add(1, 1, 0, 8'h55, 1, 0, 8'h00);
      add(1, 1, 0, 8'h66, 1, 0, 8'h00);
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'(k), 0, k == 8, 8'h00);
      add(0, 1, 0, 8'hAA, 0, 1, 8'h00);
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 8'h00, k == 8, 0, 8'(k));
      add(0, 0, 1, 8'h00, 1, 0, 8'h08);
      add(0, 0, 1, 8'h00, 1, 0, 8'h08);
      add(0, 1, 1, 8'h10, 0, 0, 8'h08);
      add(0, 1, 0, 8'h11, 0, 0, 8'h08);
      add(0, 1, 0, 8'h12, 0, 0, 8'h08);
      for (int k = 0; k < 4; k++) add(0, 1, 1, 8'(8'h13 + k), 0, 0, 8'(8'h10 + k));
      for (int k = 0; k < 5; k++) add(0, 1, 0, 8'(8'h17 + k), 0, k == 4, 8'h13);
      add(0, 1, 1, 8'hCC, 0, 0, 8'h14);
      for (int k = 0; k < 7; k++) add(0, 0, 1, 8'h00, k == 6, 0, 8'(8'h15 + k));
      add(0, 0, 1, 8'h00, 1, 0, 8'h1B);
      for (int i = 0; i < vq.size(); i++)
         step($sformatf("vec%0d", i), vq[i].rst, vq[i].wr, vq[i].rd, vq[i].din, vq[i].e, vq[i].f, vq[i].d);
      step("wrap_w0", 0, 1, 0, 8'h40, 0, 0, 8'h1B);
      step("wrap_w1", 0, 1, 0, 8'h41, 0, 0, 8'h1B);
      for (int i = 2; i < 20; i++)
         step($sformatf("wrap_rw%0d", i), 0, 1, 1, 8'(8'h40 + i), 0, 0, 8'(8'h40 + i - 2));
      step("wrap_r18", 0, 0, 1, 8'h00, 0, 0, 8'h52);
      step("wrap_r19", 0, 0, 1, 8'h00, 1, 0, 8'h53);
      for (int k = 0; k < 5; k++) step($sformatf("pre_rst_w%0d", k), 0, 1, 0, 8'(8'h60 + k), 0, 0, 8'h53);
      step("mid_rst", 1, 1, 1, 8'hEE, 1, 0, 8'h00);
      step("post_rst_rd", 0, 0, 1, 8'h00, 1, 0, 8'h00);
      step("post_rst_wr", 0, 1, 0, 8'h77, 0, 0, 8'h00);
      step("post_rst_rd2", 0, 0, 1, 8'h00, 1, 0, 8'h77);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
